// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin arbiter sharing one UART transmitter between requesters
module uart_tx_arbiter #(
  parameter int NUM_REQ       = 4,
  parameter int DATA_WIDTH    = 8,
  parameter int GAP_CYCLES    = 2,
  parameter int START_TIMEOUT = 4,
  localparam int IDW          = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                          baud_clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          tx_shift,
  output logic                          tx_send,
  output logic [DATA_WIDTH-1:0]         tx_data,
  output logic [IDW-1:0]                grant_id,
  output logic                          busy,
  output logic                          tx_abort
);

  typedef enum logic [2:0] {
    IDLE,
    SEND,
    WAIT_START,
    WAIT_DONE,
    GAP
  } state_t;

  state_t         state;
  logic [IDW-1:0] last_grant;
  logic [3:0]     cnt;
  logic           found;
  logic [IDW-1:0] winner;
  logic           grant;

  // Round-robin search: first requester above the previous winner, wrapping to 0
  always_comb begin
    found  = 1'b0;
    winner = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (!found && req_valid[(int'(last_grant) + k) % NUM_REQ]) begin
        found  = 1'b1;
        winner = IDW'((int'(last_grant) + k) % NUM_REQ);
      end
    end
  end

  // The accept pulse is only possible while idle and out of reset
  assign grant     = rst_n && (state == IDLE) && found;
  assign req_ready = grant ? (NUM_REQ'(1) << winner) : '0;
  assign busy      = (state != IDLE);

  // Frame sequencing: grant, send request, start timeout, completion, inter-frame gap
  always_ff @(posedge baud_clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      tx_send    <= 1'b0;
      tx_data    <= '0;
      grant_id   <= '0;
      last_grant <= IDW'(NUM_REQ - 1);
      tx_abort   <= 1'b0;
      cnt        <= '0;
    end else begin
      tx_abort <= 1'b0;
      case (state)
        IDLE: begin
          if (grant) begin
            tx_data    <= req_data[int'(winner)*DATA_WIDTH +: DATA_WIDTH];
            grant_id   <= winner;
            last_grant <= winner;
            tx_send    <= 1'b1;
            state      <= SEND;
          end
        end
        SEND: begin
          cnt   <= '0;
          state <= WAIT_START;
        end
        WAIT_START: begin
          if (tx_shift) begin
            tx_send <= 1'b0;
            state   <= WAIT_DONE;
          end else if (cnt == 4'(START_TIMEOUT - 1)) begin
            // Transmitter never started: drop the frame, requester is not re-accepted
            tx_send  <= 1'b0;
            tx_abort <= 1'b1;
            cnt      <= cnt + 4'd1;
            state    <= IDLE;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        WAIT_DONE: begin
          if (!tx_shift) begin
            cnt   <= '0;
            state <= (GAP_CYCLES > 0) ? GAP : IDLE;
          end
        end
        GAP: begin
          if (cnt == 4'(GAP_CYCLES - 1)) begin
            cnt   <= '0;
            state <= IDLE;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - self-checking bench for uart_tx_arbiter (gap 2 and gap 0 instances)
module tb_uart_tx_arbiter;
  localparam int N = 4;
  localparam int W = 8;
  localparam int T = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [N-1:0]     req_valid;
  logic [N*W-1:0]   req_data;
  logic [1:0]       tx_shift, send, bsy, abrt;
  logic [1:0][N-1:0] rdy;
  logic [1:0][W-1:0] txd;
  logic [1:0][1:0]  gid;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.NUM_REQ(N), .DATA_WIDTH(W), .GAP_CYCLES(2), .START_TIMEOUT(T)) dut_a (
    .baud_clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
    .req_ready(rdy[0]), .tx_shift(tx_shift[0]), .tx_send(send[0]), .tx_data(txd[0]),
    .grant_id(gid[0]), .busy(bsy[0]), .tx_abort(abrt[0]));

  uart_tx_arbiter #(.NUM_REQ(N), .DATA_WIDTH(W), .GAP_CYCLES(0), .START_TIMEOUT(T)) dut_b (
    .baud_clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
    .req_ready(rdy[1]), .tx_shift(tx_shift[1]), .tx_send(send[1]), .tx_data(txd[1]),
    .grant_id(gid[1]), .busy(bsy[1]), .tx_abort(abrt[1]));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Frame-level model: age of the frame in flight, whether shifting began, gap left
  int           gap_of [2] = '{2, 0};
  int           m_age [2], m_gap [2], m_last [2], m_id [2];
  logic [W-1:0] m_data [2];
  bit           m_started [2], m_abort [2];
  int           m_w, m_j;
  bit           m_idle;
  logic [N-1:0] e_rdy;

  int           send_cnt [2], abort_cnt [2], busy_cnt [2], gn [2];
  int           glog [2][16], gcyc [2][16];
  logic [W-1:0] dlog [2][16];
  bit           prev_rdy [2];
  int           cyc = 0;

  always @(negedge clk) begin
    cyc++;
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        m_age[i] = 0; m_gap[i] = 0; m_last[i] = N - 1; m_id[i] = 0;
        m_data[i] = '0; m_started[i] = 0; m_abort[i] = 0; prev_rdy[i] = 0;
        chk($sformatf("reset_outputs_%0d", i), {rdy[i], send[i], txd[i], gid[i], bsy[i], abrt[i]}, 64'd0);
      end else begin
        m_idle = (m_age[i] == 0) && (m_gap[i] == 0);
        m_w = -1;
        if (m_idle) begin
          for (int k = 1; k <= N; k++) begin
            m_j = (m_last[i] + k) % N;
            if (m_w < 0 && req_valid[m_j]) m_w = m_j;
          end
        end
        e_rdy = (m_w >= 0) ? N'(1 << m_w) : '0;
        chk($sformatf("req_ready_%0d", i), rdy[i], e_rdy);
        chk($sformatf("tx_send_%0d", i), send[i], (m_age[i] > 0) && !m_started[i]);
        chk($sformatf("tx_data_%0d", i), txd[i], m_data[i]);
        chk($sformatf("grant_id_%0d", i), gid[i], m_id[i]);
        chk($sformatf("busy_%0d", i), bsy[i], !m_idle);
        chk($sformatf("tx_abort_%0d", i), abrt[i], m_abort[i]);
        if (send[i]) send_cnt[i]++;
        if (abrt[i]) abort_cnt[i]++;
        if (bsy[i]) busy_cnt[i]++;
        if (prev_rdy[i] && gn[i] < 16) begin
          glog[i][gn[i]] = gid[i];
          dlog[i][gn[i]] = txd[i];
          gcyc[i][gn[i]] = cyc - 1;
          gn[i]++;
        end
        prev_rdy[i] = |rdy[i];
        m_abort[i] = 0;
        if (m_w >= 0) begin
          m_last[i] = m_w; m_id[i] = m_w; m_data[i] = req_data[m_w*W +: W];
          m_age[i] = 1; m_started[i] = 0;
        end else if (m_age[i] > 0) begin
          if (m_started[i]) begin
            if (!tx_shift[i]) begin m_age[i] = 0; m_gap[i] = gap_of[i]; end
          end else if (m_age[i] >= 2 && tx_shift[i]) begin
            m_started[i] = 1;
          end else if (m_age[i] == 1 + T) begin
            m_age[i] = 0; m_abort[i] = 1;
          end else begin
            m_age[i]++;
          end
        end else if (m_gap[i] > 0) begin
          m_gap[i]--;
        end
      end
    end
  end

  // Transmitter stand-in: starts shifting dly cycles after tx_send, shifts for len cycles
  bit xmit_en = 1'b1;
  int dly = 1, len = 11;
  int wcnt [2], scnt [2];
  initial begin
    tx_shift = '0;
    wcnt = '{0, 0}; scnt = '{0, 0};
    forever begin
      @(posedge clk); #1;
      for (int i = 0; i < 2; i++) begin
        if (!rst_n) begin
          tx_shift[i] = 0; wcnt[i] = 0; scnt[i] = 0;
        end else if (scnt[i] > 0) begin
          tx_shift[i] = 1; scnt[i]--;
        end else begin
          tx_shift[i] = 0;
          if (send[i] && xmit_en) begin
            if (wcnt[i] == dly) begin tx_shift[i] = 1; scnt[i] = len - 1; wcnt[i] = 0; end
            else wcnt[i]++;
          end else wcnt[i] = 0;
        end
      end
    end
  end

  task automatic clear_stats();
    for (int i = 0; i < 2; i++) begin
      send_cnt[i] = 0; abort_cnt[i] = 0; busy_cnt[i] = 0; gn[i] = 0;
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 0;
    cycles(2);
    rst_n = 1;
  endtask

  task automatic pulse_valid(input logic [N-1:0] v);
    req_valid = v;
    cycles(1);
    req_valid = '0;
  endtask

  task automatic wait_grants(input int inst, input int n, input string name);
    for (int k = 0; k < 300 && gn[inst] < n; k++) @(negedge clk);
    chk(name, gn[inst] >= n, 1'b1);
  endtask

  initial begin
    rst_n = 0; req_valid = '0; req_data = '0;
    clear_stats();
    cycles(3);
    rst_n = 1;

    // Single request from requester 0
    req_data = {8'h00, 8'h00, 8'h00, 8'hA5};
    clear_stats();
    pulse_valid(4'b0001);
    cycles(30);
    chk("single_grant_count", gn[0], 1);
    chk("single_grant_id", glog[0][0], 0);
    chk("single_tx_data", dlog[0][0], 8'hA5);
    chk("single_busy_cycles_gap2", busy_cnt[0], 15);
    chk("single_busy_cycles_gap0", busy_cnt[1], 13);

    // All requesters active: round-robin order from reset
    do_reset();
    clear_stats();
    req_data = {8'h44, 8'h33, 8'h22, 8'h11};
    req_valid = 4'b1111;
    wait_grants(0, 5, "rr_grants_reached");
    @(posedge clk); #1;
    req_valid = '0;
    cycles(40);
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("rr_grant_%0d", k), glog[0][k], k % 4);
      chk($sformatf("rr_data_%0d", k), dlog[0][k], 8'h11 * ((k % 4) + 1));
    end

    // Start timeout: transmitter never responds
    do_reset();
    clear_stats();
    xmit_en = 0;
    pulse_valid(4'b0001);
    cycles(12);
    chk("timeout_send_cycles_a", send_cnt[0], 1 + T);
    chk("timeout_send_cycles_b", send_cnt[1], 1 + T);
    chk("timeout_abort_a", abort_cnt[0], 1);
    chk("timeout_abort_b", abort_cnt[1], 1);
    xmit_en = 1;
    req_valid = 4'b0011;
    @(negedge clk); #1;
    chk("timeout_next_grant", rdy[0], 4'b0010);
    @(posedge clk); #1;
    req_valid = '0;
    cycles(40);

    // Reset while the transmitter is shifting
    clear_stats();
    pulse_valid(4'b0001);
    cycles(6);
    @(negedge clk); #2;
    rst_n = 0;
    #1;
    chk("async_reset_a", {rdy[0], send[0], txd[0], gid[0], bsy[0], abrt[0]}, 64'd0);
    chk("async_reset_b", {rdy[1], send[1], txd[1], gid[1], bsy[1], abrt[1]}, 64'd0);
    cycles(2);
    rst_n = 1;
    req_valid = 4'b1000;
    @(negedge clk); #1;
    chk("post_reset_grant_a", rdy[0], 4'b1000);
    chk("post_reset_grant_b", rdy[1], 4'b1000);
    @(posedge clk); #1;
    req_valid = '0;
    cycles(40);
    chk("post_reset_no_abort", abort_cnt[0] + abort_cnt[1], 0);

    // Back-to-back frames with payload churn after acceptance
    clear_stats();
    req_valid = 4'b0011;
    for (int k = 0; k < 300 && gn[0] < 3; k++) begin
      req_data = {$urandom, $urandom};
      cycles(1);
    end
    chk("b2b_grants_reached", gn[0] >= 3, 1'b1);
    req_valid = '0;
    chk("b2b_interval_gap2", gcyc[0][1] - gcyc[0][0], 16);
    chk("b2b_interval_gap0", gcyc[1][1] - gcyc[1][0], 14);
    cycles(40);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_REQ, default 4, number of requesters sharing the UART transmitter (2..8).
REQ-002 The block SHALL have parameter DATA_WIDTH, default 8, payload bits per frame.
REQ-003 The block SHALL have parameter GAP_CYCLES, default 2, idle baud cycles forced between frames (0..15).
REQ-004 The block SHALL have parameter START_TIMEOUT, default 4, baud cycles to wait for transmitter start before abort (1..15).
REQ-005 The block SHALL have port baud_clk  input  1  sole clock, all state on rising edge.
REQ-006 The block SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-007 The block SHALL have port req_valid  input  NUM_REQ  per-requester frame request, level.
REQ-008 The block SHALL have port req_data  input  NUM_REQ*DATA_WIDTH  payloads, requester i at bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-009 The block SHALL have port req_ready  output  NUM_REQ  one-hot accept pulse, payload captured that cycle.
REQ-010 The block SHALL have port tx_shift  input  1  transmitter shift status, high while frame shifts out.
REQ-011 The block SHALL have port tx_send  output  1  send request to transmitter.
REQ-012 The block SHALL have port tx_data  output  DATA_WIDTH  payload presented to transmitter.
REQ-013 The block SHALL have port grant_id  output  clog2(NUM_REQ)  index of requester currently owning transmitter.
REQ-014 The block SHALL have port busy  output  1  high in any state except IDLE.
REQ-015 The block SHALL have port tx_abort  output  1  one-cycle pulse on start timeout.

Function
REQ-016 The FSM SHALL have states IDLE, SEND, WAIT_START, WAIT_DONE, GAP.
REQ-017 IDLE: if any req_valid bit set, grant SHALL go round-robin to first set bit searching from last_grant+1 upward with wrap to 0; same cycle req_ready[winner]=1, payload registered into tx_data, grant_id and last_grant updated, next state SEND.
REQ-018 req_ready SHALL be zero in every cycle other than the IDLE grant cycle; at most one bit set.
REQ-019 SEND: tx_send=1 for one cycle, next state WAIT_START, timeout counter cleared.
REQ-020 WAIT_START: tx_send SHALL stay 1; tx_shift=1 moves to WAIT_DONE with tx_send=0 next cycle; counter increments each cycle otherwise.
REQ-021 WAIT_START: when counter reaches START_TIMEOUT without tx_shift, tx_abort SHALL pulse 1 cycle, tx_send drop, next state IDLE (frame dropped, requester not re-accepted).
REQ-022 WAIT_DONE: tx_send=0; tx_shift=0 moves to GAP (GAP_CYCLES>0) or IDLE (GAP_CYCLES=0).
REQ-023 GAP: stay exactly GAP_CYCLES cycles, then IDLE; new requests ignored.
REQ-024 tx_data and grant_id SHALL hold stable from grant until next grant.
REQ-025 Changes to req_valid/req_data after acceptance SHALL not affect the frame in flight.
REQ-026 Requester holding req_valid high SHALL get one frame per grant round; with all requesters active, grant order 0,1,..,NUM_REQ-1,0.
REQ-027 Timeout and gap counters SHALL be 4 bits, saturating never required given parameter bounds.

Reset
REQ-028 On rst_n=0, immediately and independent of clock: state IDLE, tx_send=0, tx_data=0, req_ready=0, grant_id=0, busy=0, tx_abort=0, counters 0, last_grant=NUM_REQ-1 (requester 0 first after reset).
REQ-029 Reset asserted mid-frame SHALL abandon the frame with no tx_abort pulse; after release first grant in first cycle with req_valid set.

Verification
REQ-030 Single request: req_valid=0001, data[0]=0xA5, tx_shift high 11 cycles after send -> req_ready=0001 one cycle, tx_data=0xA5, tx_send 1 until tx_shift, busy through 2 gap cycles.
REQ-031 All valid 1111, payloads 0x11/0x22/0x33/0x44 -> grants in order 0,1,2,3,0, tx_data sequence 0x11,0x22,0x33,0x44.
REQ-032 Timeout: grant with tx_shift held 0 -> tx_send high 1+4 cycles, tx_abort one pulse, return IDLE, next grant goes to next requester.
REQ-033 Reset mid WAIT_DONE -> all outputs 0 asynchronously; after release req_valid=1000 granted to 3 while req 0 idle.
REQ-034 GAP_CYCLES=0 back-to-back: tx_shift falls -> IDLE next cycle, new req_ready following cycle; req_data changed after accept -> tx_data unchanged.
